// File: rtl/rv_decode_stage.sv
// R-type decode stage: splits RV32I words into fields, reads two operands from a
// 32x32 register file (with writeback bypass) and hands them to the ALU via one output register.
module rv_decode_stage #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic               wb_en,
  input  logic [4:0]         wb_rd,
  input  logic [31:0]        wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [4:0]         rd,
  output logic [31:0]        data1_out,
  output logic [31:0]        data2_out,
  output logic               illegal,
  output logic [COUNT_W-1:0] decode_count
);

  logic [31:0]        r_regs [32];
  logic               r_valid;
  logic [6:0]         r_opcode;
  logic [2:0]         r_funct3;
  logic [6:0]         r_funct7;
  logic [4:0]         r_rd;
  logic [31:0]        r_data1;
  logic [31:0]        r_data2;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;

  logic        w_accept;
  logic        w_out_hs;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_illegal;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_valid && out_ready;

  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];

  // x0 is hard-wired; a same-cycle writeback to the source wins over the array.
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (w_rs1 != 5'd0) w_op1 = (wb_en && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
    if (w_rs2 != 5'd0) w_op2 = (wb_en && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];
  end

  always_comb begin
    w_illegal = 1'b1;
    if (instr[6:0] == 7'b0110011) begin
      case ({instr[14:12], instr[31:25]})
        {3'b000, 7'b0000000},
        {3'b000, 7'b0100000},
        {3'b001, 7'b0000000},
        {3'b101, 7'b0000000},
        {3'b100, 7'b0000000},
        {3'b110, 7'b0000000},
        {3'b111, 7'b0000000}: w_illegal = 1'b0;
        default:              w_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_rd      <= '0;
      r_data1   <= '0;
      r_data2   <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_opcode  <= instr[6:0];
      r_funct3  <= instr[14:12];
      r_funct7  <= instr[31:25];
      r_rd      <= instr[11:7];
      r_data1   <= w_op1;
      r_data2   <= w_op2;
      r_illegal <= w_illegal;
    end else if (w_out_hs) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_count <= '0;
    else if (w_out_hs) r_count <= r_count + COUNT_W'(1);
  end

  assign out_valid    = r_valid;
  assign opcode       = r_opcode;
  assign funct3       = r_funct3;
  assign funct7       = r_funct7;
  assign rd           = r_rd;
  assign data1_out    = r_data1;
  assign data2_out    = r_data2;
  assign illegal      = r_illegal;
  assign decode_count = r_count;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: inputs change on the falling edge,
// outputs are checked just after it, away from the rising edge.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] data1_out;
  logic [31:0] data2_out;
  logic        illegal;
  logic [31:0] decode_count;

  int n_tests = 0;
  int n_fail  = 0;

  rv_decode_stage #(.COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .data1_out(data1_out), .data2_out(data2_out), .illegal(illegal),
    .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction

  // advance one full cycle, ending 1ns after the next falling edge
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
  endtask

  logic [2:0]  s_f3 [8];
  logic [6:0]  s_f7 [8];
  logic [31:0] sd1;

  initial begin
    s_f3 = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd4, 3'd6, 3'd7, 3'd0};
    s_f7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01};

    rst_n = 1'b0;
    idle_inputs();
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", decode_count, 0);
    chk("rst_data1", data1_out, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // x1 = 5, x2 = 3
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; cyc();
    wb_rd = 5'd2; wb_data = 32'd3; cyc();
    wb_en = 1'b0;

    // add x3,x1,x2
    in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b0; #1;
    chk("add_in_ready", in_ready, 1);
    cyc();
    chk("add_valid", out_valid, 1);
    chk("add_opcode", opcode, 7'b0110011);
    chk("add_funct3", funct3, 0);
    chk("add_funct7", funct7, 0);
    chk("add_rd", rd, 3);
    chk("add_data1", data1_out, 5);
    chk("add_data2", data2_out, 3);
    chk("add_illegal", illegal, 0);
    chk("add_count", decode_count, 0);

    // sub replaces add in the same edge as the add's handshake
    instr = 32'h402081B3; out_ready = 1'b1; cyc();
    chk("sub_valid", out_valid, 1);
    chk("sub_count", decode_count, 1);
    in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      cyc();
      chk("bp_valid", out_valid, 1);
      chk("bp_funct7", funct7, 7'h20);
      chk("bp_data1", data1_out, 5);
      chk("bp_count", decode_count, 1);
      wb_en = 1'b0;
    end
    // restore x1 = 5 while draining
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    out_ready = 1'b1; cyc();
    wb_en = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_count", decode_count, 2);
    chk("drain_funct7_hold", funct7, 7'h20);

    // bypass on rs1
    in_valid = 1'b1; instr = 32'h002081B3;
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF; cyc();
    chk("byp_data1", data1_out, 32'hDEADBEEF);
    chk("byp_data2", data2_out, 3);
    chk("byp_count", decode_count, 2);

    // write to x0 is ignored, then read x0 (also with a same-cycle x0 write)
    in_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h1234; cyc();
    chk("x0w_count", decode_count, 3);
    chk("x0w_valid", out_valid, 0);
    in_valid = 1'b1; instr = 32'h000001B3; wb_data = 32'hFFFF; cyc();
    wb_en = 1'b0;
    chk("x0_data1", data1_out, 0);
    chk("x0_data2", data2_out, 0);
    chk("x0_count", decode_count, 3);

    // 8 back-to-back, x1 now from the array
    for (int i = 0; i < 8; i++) begin
      instr = rtype(s_f7[i], 5'd2, 5'd1, s_f3[i], 5'(i + 4));
      #1;
      chk("str_in_ready", in_ready, 1);
      cyc();
      chk("str_valid", out_valid, 1);
      chk("str_rd", rd, i + 4);
      chk("str_funct3", funct3, s_f3[i]);
      chk("str_funct7", funct7, s_f7[i]);
      chk("str_illegal", illegal, (i == 7) ? 1 : 0);
      sd1 = data1_out;
      chk("str_data1", sd1, 32'hDEADBEEF);
      chk("str_count", decode_count, 4 + i);
    end
    in_valid = 1'b0; cyc();
    chk("str_end_valid", out_valid, 0);
    chk("str_end_count", decode_count, 12);

    // addi is illegal but passes through
    in_valid = 1'b1; instr = 32'h00508093; out_ready = 1'b0; cyc();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_illegal", illegal, 1);
    chk("addi_opcode", opcode, 7'b0010011);
    chk("addi_rd", rd, 1);
    chk("addi_funct3", funct3, 0);
    chk("addi_data1", data1_out, 32'hDEADBEEF);

    // async reset while held
    rst_n = 1'b0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", decode_count, 0);
    chk("arst_opcode", opcode, 0);
    chk("arst_data1", data1_out, 0);
    cyc();
    rst_n = 1'b1;
    in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b1; cyc();
    in_valid = 1'b0;
    chk("post_rst_data1", data1_out, 0);
    chk("post_rst_data2", data2_out, 0);
    chk("post_rst_valid", out_valid, 1);
    cyc();
    chk("post_rst_count", decode_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Decode stage that feeds the R-type ALU: accepts 32-bit RV32I instruction words over a valid/ready handshake, splits them into opcode, funct3 and funct7, reads both source operands from an internal 32x32 register file, and presents the result to the ALU in a single-entry pipeline register. It is the producing end of the ALU's input interface. It also owns the register-file write port used by writeback.

## Interface
- COUNT_W, 32, width of the decoded-instruction counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage can accept instr this cycle
- instr  in  32  RV32I instruction word
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write address
- wb_data  in  32  write data
- out_valid  out  1  output register holds a decoded instruction
- out_ready  in  1  ALU side consumes the output this cycle
- opcode  out  7  instr[6:0]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- rd  out  5  instr[11:7]
- data1_out  out  32  value of rs1 (instr[19:15])
- data2_out  out  32  value of rs2 (instr[24:20])
- illegal  out  1  instruction is not one of the supported R-type operations
- decode_count  out  COUNT_W  number of output handshakes completed

## Operation
- Reset (asynchronous, rst_n low): out_valid=0; opcode, funct3, funct7, rd, data1_out, data2_out, illegal all 0; decode_count=0; all 32 registers cleared to 0. Reset mid-transfer discards the held instruction.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept, the output register captures the fields, both operands, and illegal; out_valid is set. If out_valid && out_ready && !in_valid, out_valid clears and fields hold their last value.
- Output handshake = out_valid && out_ready; decode_count increments by 1 on each, wrapping from 2^COUNT_W-1 to 0.
- Operand read: register x0 always reads 0. If wb_en && wb_rd==rs && rs!=0 in the accept cycle, the operand is wb_data (bypass); otherwise the stored register value.
- Register write: on rising edge with wb_en && wb_rd!=0, reg[wb_rd]=wb_data. Writes to x0 are ignored. Writes occur regardless of handshake state.
- Operands are sampled only at accept; a later write to rs1/rs2 while the instruction is held does not update data1_out/data2_out.
- illegal=0 only when opcode==7'b0110011 and {funct3,funct7} is one of: add {000,0000000}, sub {000,0100000}, sll {001,0000000}, srl {101,0000000}, xor {100,0000000}, or {110,0000000}, and {111,0000000}. Otherwise illegal=1; the instruction is still passed through with all fields intact.
- No instruction is dropped or duplicated: every accept produces exactly one output handshake.

## Timing
- Latency: accept in cycle N -> out_valid=1 with decoded fields in cycle N+1.
- Throughput: one instruction per cycle while out_ready stays high.
- Backpressure: out_valid && !out_ready -> in_ready=0, and all outputs hold stable until out_ready is high.
- Simultaneous output handshake and accept: the new instruction replaces the old one in the same edge, out_valid stays 1, and decode_count increments.
- Write-then-read: a write in cycle N is visible through the bypass in cycle N and from the array in cycle N+1.

## Test plan
- Reset, then write x1=5 and x2=3; send add x3,x1,x2 (0x002081B3) -> next cycle out_valid=1, opcode=0110011, funct3=000, funct7=0000000, rd=3, data1_out=5, data2_out=3, illegal=0.
- Send sub (0x402081B3) with out_ready held 0 for 3 cycles -> in_ready=0 and outputs stable for all 3 cycles; after out_ready=1, one handshake and decode_count=1.
- Bypass: wb_en=1, wb_rd=1, wb_data=0xDEADBEEF in the same cycle as accepting add x3,x1,x2 -> data1_out=0xDEADBEEF; a write to x0 followed by reading x0 -> 0.
- Back-to-back stream of 8 instructions with out_ready=1 -> 8 consecutive out_valid cycles in order, decode_count=8, no gaps.
- Illegal: addi (0x00508093) and funct7=0000001 R-type (mul, 0x022081B3) -> illegal=1, fields passed through unchanged.
- Assert rst_n low while an instruction is held -> out_valid=0, decode_count=0, and the register file reads 0 immediately (asynchronous).
